// File: rtl/lookup_cfg_pkg.sv
// Shared opcodes, header layout and sequencer state encoding for the
// lookup_engine configuration path.
package lookup_cfg_pkg;

    localparam logic [3:0] OP_WR_ENTRY = 4'd1;
    localparam logic [3:0] OP_WR_KEY   = 4'd2;
    localparam logic [3:0] OP_WR_ACT   = 4'd3;

    localparam int HDR_OP_HI    = 63;
    localparam int HDR_OP_LO    = 60;
    localparam int HDR_STAGE_HI = 59;
    localparam int HDR_STAGE_LO = 56;

    localparam int DEF_KEY_LEN  = 896;
    localparam int DEF_C_DATA_W = 64;
    localparam int KEY_BEATS    = DEF_KEY_LEN / DEF_C_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_MASK,
        ST_ACT,
        ST_COMMIT_CAM,
        ST_COMMIT_ACT,
        ST_DRAIN
    } cfg_state_e;

    function automatic logic is_known_op(input logic [3:0] op);
        return (op == OP_WR_ENTRY) || (op == OP_WR_KEY) || (op == OP_WR_ACT);
    endfunction

endpackage

// File: rtl/cfg_wide_shreg.sv
// Assembles a wide word from DATA_W-bit beats, most-significant beat first,
// by shifting each new beat in from the right.
module cfg_wide_shreg #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     shift_en,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W*WORDS-1:0]  word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (clr) begin
            word <= '0;
        end else if (shift_en) begin
            word <= {word[DATA_W*WORDS-DATA_W-1:0], din};
        end
    end

endmodule

// File: rtl/lookup_cfg_ctrl.sv
// Configuration sequencer for one lookup_engine stage: parses beat-serial
// control commands and issues CAM / action RAM write strobes.
module lookup_cfg_ctrl
    import lookup_cfg_pkg::*;
#(
    parameter int STAGE      = 0,
    parameter int KEY_LEN    = 896,
    parameter int MASK_LEN   = 896,
    parameter int ACTION_LEN = 25,
    parameter int ADDR_W     = 4,
    parameter int C_DATA_W   = 64
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [C_DATA_W-1:0]   cmd_data,
    input  logic                  cmd_valid,
    input  logic                  cmd_last,
    output logic                  cmd_ready,
    output logic [KEY_LEN-1:0]    lookup_din,
    output logic [MASK_LEN-1:0]   lookup_din_mask,
    output logic [ADDR_W-1:0]     lookup_din_addr,
    output logic                  lookup_din_en,
    output logic [ACTION_LEN-1:0] action_data_in,
    output logic [ADDR_W-1:0]     action_addr,
    output logic                  action_en,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    output logic [15:0]           cfg_wr_cnt
);

    localparam int         N_KEY_BEATS  = KEY_LEN / C_DATA_W;
    localparam int         N_MASK_BEATS = MASK_LEN / C_DATA_W;
    localparam logic [3:0] KEY_LAST     = 4'(N_KEY_BEATS - 1);
    localparam logic [3:0] MASK_LAST    = 4'(N_MASK_BEATS - 1);
    localparam logic [3:0] STAGE_ID     = 4'(STAGE);

    cfg_state_e            state;
    logic [3:0]            op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [3:0]            beat_cnt;
    logic [ACTION_LEN-1:0] act_q;
    logic                  drain_err;
    logic                  ready_en;

    logic                  beat_ok;
    logic [3:0]            hdr_op;
    logic [3:0]            hdr_stage;
    logic [KEY_LEN-1:0]    key_word;
    logic [MASK_LEN-1:0]   mask_word;
    logic [MASK_LEN-1:0]   mask_next;

    // ready_en keeps cmd_ready low while reset is held and for the first edge after it
    assign cmd_ready = ready_en && (state != ST_COMMIT_CAM) && (state != ST_COMMIT_ACT);
    assign cfg_busy  = (state != ST_IDLE);
    assign beat_ok   = cmd_valid && cmd_ready;
    assign hdr_op    = cmd_data[HDR_OP_HI:HDR_OP_LO];
    assign hdr_stage = cmd_data[HDR_STAGE_HI:HDR_STAGE_LO];
    assign mask_next = {mask_word[MASK_LEN-C_DATA_W-1:0], cmd_data};

    cfg_wide_shreg #(
        .DATA_W (C_DATA_W),
        .WORDS  (N_KEY_BEATS)
    ) u_key_shreg (
        .clk      (axis_clk),
        .rst_n    (aresetn),
        .clr      (beat_ok && (state == ST_IDLE)),
        .shift_en (beat_ok && (state == ST_KEY)),
        .din      (cmd_data),
        .word     (key_word)
    );

    cfg_wide_shreg #(
        .DATA_W (C_DATA_W),
        .WORDS  (N_MASK_BEATS)
    ) u_mask_shreg (
        .clk      (axis_clk),
        .rst_n    (aresetn),
        .clr      (beat_ok && (state == ST_IDLE)),
        .shift_en (beat_ok && (state == ST_MASK)),
        .din      (cmd_data),
        .word     (mask_word)
    );

    // Strobes are raised on the edge that enters the matching COMMIT state,
    // so each strobe is high for exactly the cycle spent in that state.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= ST_IDLE;
            op_q            <= '0;
            addr_q          <= '0;
            beat_cnt        <= '0;
            act_q           <= '0;
            drain_err       <= 1'b0;
            ready_en        <= 1'b0;
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= '0;
            lookup_din_en   <= 1'b0;
            action_data_in  <= '0;
            action_addr     <= '0;
            action_en       <= 1'b0;
            cfg_err         <= 1'b0;
            cfg_wr_cnt      <= '0;
        end else begin
            ready_en      <= 1'b1;
            lookup_din_en <= 1'b0;
            action_en     <= 1'b0;
            cfg_err       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (beat_ok) begin
                        op_q      <= hdr_op;
                        addr_q    <= cmd_data[ADDR_W-1:0];
                        beat_cnt  <= '0;
                        drain_err <= 1'b0;
                        if (hdr_stage != STAGE_ID) begin
                            if (!cmd_last) state <= ST_DRAIN;
                        end else if (!is_known_op(hdr_op)) begin
                            cfg_err <= 1'b1;
                            if (!cmd_last) state <= ST_DRAIN;
                        end else if (cmd_last) begin
                            cfg_err <= 1'b1;
                        end else if (hdr_op == OP_WR_ACT) begin
                            state <= ST_ACT;
                        end else begin
                            state <= ST_KEY;
                        end
                    end
                end

                ST_KEY: begin
                    if (beat_ok) begin
                        if (cmd_last) begin
                            cfg_err <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (beat_cnt == KEY_LAST) begin
                            beat_cnt <= '0;
                            state    <= ST_MASK;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end

                ST_MASK: begin
                    if (beat_ok) begin
                        if (beat_cnt != MASK_LAST) begin
                            if (cmd_last) begin
                                cfg_err <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                beat_cnt <= beat_cnt + 4'd1;
                            end
                        end else if (op_q == OP_WR_ENTRY) begin
                            if (cmd_last) begin
                                cfg_err <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                state <= ST_ACT;
                            end
                        end else if (!cmd_last) begin
                            drain_err <= 1'b1;
                            state     <= ST_DRAIN;
                        end else begin
                            lookup_din      <= key_word;
                            lookup_din_mask <= mask_next;
                            lookup_din_addr <= addr_q;
                            lookup_din_en   <= 1'b1;
                            cfg_wr_cnt      <= cfg_wr_cnt + 16'd1;
                            state           <= ST_COMMIT_CAM;
                        end
                    end
                end

                ST_ACT: begin
                    if (beat_ok) begin
                        if (!cmd_last) begin
                            drain_err <= 1'b1;
                            state     <= ST_DRAIN;
                        end else if (op_q == OP_WR_ENTRY) begin
                            act_q           <= cmd_data[ACTION_LEN-1:0];
                            lookup_din      <= key_word;
                            lookup_din_mask <= mask_word;
                            lookup_din_addr <= addr_q;
                            lookup_din_en   <= 1'b1;
                            state           <= ST_COMMIT_CAM;
                        end else begin
                            action_data_in <= cmd_data[ACTION_LEN-1:0];
                            action_addr    <= addr_q;
                            action_en      <= 1'b1;
                            cfg_wr_cnt     <= cfg_wr_cnt + 16'd1;
                            state          <= ST_COMMIT_ACT;
                        end
                    end
                end

                ST_COMMIT_CAM: begin
                    if (op_q == OP_WR_ENTRY) begin
                        action_data_in <= act_q;
                        action_addr    <= addr_q;
                        action_en      <= 1'b1;
                        cfg_wr_cnt     <= cfg_wr_cnt + 16'd1;
                        state          <= ST_COMMIT_ACT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_COMMIT_ACT: begin
                    state <= ST_IDLE;
                end

                // drain_err marks a command that overran its expected length
                ST_DRAIN: begin
                    if (beat_ok && cmd_last) begin
                        cfg_err   <= drain_err;
                        drain_err <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lookup_cfg_ctrl.sv
// Directed bench for lookup_cfg_ctrl: command sequences with hand-computed
// strobe timing, data, counter and error expectations.
module tb_lookup_cfg_ctrl;

    localparam int KL = 896;
    localparam int AL = 25;

    logic          axis_clk = 1'b0;
    logic          aresetn;
    logic [63:0]   cmd_data;
    logic          cmd_valid;
    logic          cmd_last;
    logic          cmd_ready;
    logic [KL-1:0] lookup_din;
    logic [KL-1:0] lookup_din_mask;
    logic [3:0]    lookup_din_addr;
    logic          lookup_din_en;
    logic [AL-1:0] action_data_in;
    logic [3:0]    action_addr;
    logic          action_en;
    logic          cfg_busy;
    logic          cfg_err;
    logic [15:0]   cfg_wr_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc;
    int cam_cnt = 0, act_cnt = 0, err_cnt = 0;
    int cam_cyc = -1, act_cyc = -1;
    int cam_base, act_base, err_base;
    logic [KL-1:0] exp_key, exp_mask;

    lookup_cfg_ctrl #(
        .STAGE      (0),
        .KEY_LEN    (896),
        .MASK_LEN   (896),
        .ACTION_LEN (25),
        .ADDR_W     (4),
        .C_DATA_W   (64)
    ) dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .cmd_data        (cmd_data),
        .cmd_valid       (cmd_valid),
        .cmd_last        (cmd_last),
        .cmd_ready       (cmd_ready),
        .lookup_din      (lookup_din),
        .lookup_din_mask (lookup_din_mask),
        .lookup_din_addr (lookup_din_addr),
        .lookup_din_en   (lookup_din_en),
        .action_data_in  (action_data_in),
        .action_addr     (action_addr),
        .action_en       (action_en),
        .cfg_busy        (cfg_busy),
        .cfg_err         (cfg_err),
        .cfg_wr_cnt      (cfg_wr_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle so one-cycle strobes are never missed
    always @(negedge axis_clk) begin
        if (lookup_din_en) begin
            cam_cnt = cam_cnt + 1;
            cam_cyc = cyc;
        end
        if (action_en) begin
            act_cnt = act_cnt + 1;
            act_cyc = cyc;
        end
        if (cfg_err) err_cnt = err_cnt + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] hdr(input logic [3:0] op, input logic [3:0] stg,
                                        input logic [3:0] addr);
        return {op, stg, 52'h0, addr};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge
    task automatic apply_stimulus(input logic [63:0] d, input logic last);
        int waited;
        waited = 0;
        cmd_data  = d;
        cmd_last  = last;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 40) begin
            @(negedge axis_clk);
            waited++;
        end
        if (!cmd_ready) check_output("beat_accept_timeout", {63'h0, cmd_ready}, 64'h1);
        @(negedge axis_clk);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge axis_clk);
    endtask

    task automatic snap();
        cam_base = cam_cnt;
        act_base = act_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        aresetn   = 1'b0;
        cmd_data  = '0;
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        idle(2);

        $display("[TB] reset state");
        check_output("rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        check_output("rst_busy", {63'h0, cfg_busy}, 64'h0);
        check_output("rst_din_en", {63'h0, lookup_din_en}, 64'h0);
        check_output("rst_wr_cnt", {48'h0, cfg_wr_cnt}, 64'h0);
        aresetn = 1'b1;
        idle(2);

        $display("[TB] WR_ENTRY stage 0 addr 5");
        snap();
        exp_key = '0;
        apply_stimulus(hdr(4'd1, 4'd0, 4'd5), 1'b0);
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(64'(i), 1'b0);
            exp_key = {exp_key[KL-65:0], 64'(i)};
        end
        for (int i = 0; i < 14; i++) apply_stimulus({64{1'b1}}, 1'b0);
        apply_stimulus(64'h1ABCDEF, 1'b1);
        check_output("e_din_en_n1", {63'h0, lookup_din_en}, 64'h1);
        check_output("e_ready_n1", {63'h0, cmd_ready}, 64'h0);
        check_output("e_key_top", lookup_din[895:832], 64'h0);
        check_output("e_key_bot", lookup_din[63:0], 64'hD);
        check_output("e_key_full", {63'h0, lookup_din === exp_key}, 64'h1);
        check_output("e_mask_full", {63'h0, lookup_din_mask === {KL{1'b1}}}, 64'h1);
        check_output("e_din_addr", {60'h0, lookup_din_addr}, 64'h5);
        idle(1);
        check_output("e_act_en_n2", {63'h0, action_en}, 64'h1);
        check_output("e_din_en_n2", {63'h0, lookup_din_en}, 64'h0);
        check_output("e_act_data", {39'h0, action_data_in}, 64'h1ABCDEF);
        check_output("e_act_addr", {60'h0, action_addr}, 64'h5);
        check_output("e_ready_n2", {63'h0, cmd_ready}, 64'h0);
        idle(1);
        check_output("e_ready_n3", {63'h0, cmd_ready}, 64'h1);
        check_output("e_busy_n3", {63'h0, cfg_busy}, 64'h0);
        check_output("e_wr_cnt", {48'h0, cfg_wr_cnt}, 64'h1);
        idle(3);
        check_output("e_cam_pulses", 64'(cam_cnt - cam_base), 64'h1);
        check_output("e_act_pulses", 64'(act_cnt - act_base), 64'h1);
        check_output("e_act_after_cam", 64'(act_cyc - cam_cyc), 64'h1);
        check_output("e_err_pulses", 64'(err_cnt - err_base), 64'h0);

        $display("[TB] WR_ACT addr 3 with bubbles");
        snap();
        apply_stimulus(hdr(4'd3, 4'd0, 4'd3), 1'b0);
        idle(1);
        apply_stimulus(64'h0FF, 1'b1);
        check_output("a_act_en", {63'h0, action_en}, 64'h1);
        check_output("a_act_addr", {60'h0, action_addr}, 64'h3);
        check_output("a_act_data", {39'h0, action_data_in}, 64'hFF);
        check_output("a_wr_cnt", {48'h0, cfg_wr_cnt}, 64'h2);
        idle(1);
        check_output("a_ready_n2", {63'h0, cmd_ready}, 64'h1);
        idle(2);
        check_output("a_cam_pulses", 64'(cam_cnt - cam_base), 64'h0);
        check_output("a_act_pulses", 64'(act_cnt - act_base), 64'h1);
        check_output("a_key_hold", lookup_din[63:0], 64'hD);

        $display("[TB] foreign stage drained");
        snap();
        apply_stimulus(hdr(4'd1, 4'd1, 4'd7), 1'b0);
        for (int i = 0; i < 30; i++) apply_stimulus(64'hA5A5_0000_0000_0000 | 64'(i), i == 29);
        check_output("s_busy", {63'h0, cfg_busy}, 64'h0);
        idle(3);
        check_output("s_cam_pulses", 64'(cam_cnt - cam_base), 64'h0);
        check_output("s_act_pulses", 64'(act_cnt - act_base), 64'h0);
        check_output("s_err_pulses", 64'(err_cnt - err_base), 64'h0);
        check_output("s_wr_cnt", {48'h0, cfg_wr_cnt}, 64'h2);

        $display("[TB] early last in key, then WR_ACT");
        snap();
        apply_stimulus(hdr(4'd1, 4'd0, 4'd4), 1'b0);
        for (int i = 0; i < 10; i++) apply_stimulus(64'h1111 * 64'(i), i == 9);
        check_output("k_err_pulse", {63'h0, cfg_err}, 64'h1);
        check_output("k_busy", {63'h0, cfg_busy}, 64'h0);
        idle(1);
        check_output("k_err_clear", {63'h0, cfg_err}, 64'h0);
        apply_stimulus(hdr(4'd3, 4'd0, 4'd9), 1'b0);
        apply_stimulus(64'h155AA55, 1'b1);
        check_output("k_act_en", {63'h0, action_en}, 64'h1);
        check_output("k_act_addr", {60'h0, action_addr}, 64'h9);
        check_output("k_act_data", {39'h0, action_data_in}, 64'h155AA55);
        idle(3);
        check_output("k_cam_pulses", 64'(cam_cnt - cam_base), 64'h0);
        check_output("k_act_pulses", 64'(act_cnt - act_base), 64'h1);
        check_output("k_err_pulses", 64'(err_cnt - err_base), 64'h1);
        check_output("k_wr_cnt", {48'h0, cfg_wr_cnt}, 64'h3);

        $display("[TB] unknown opcode, then overlong WR_ENTRY");
        snap();
        apply_stimulus(hdr(4'd7, 4'd0, 4'd1), 1'b0);
        check_output("u_err_pulse", {63'h0, cfg_err}, 64'h1);
        for (int i = 0; i < 3; i++) apply_stimulus(64'(i + 100), i == 2);
        check_output("u_err_at_last", {63'h0, cfg_err}, 64'h0);
        check_output("u_busy", {63'h0, cfg_busy}, 64'h0);
        apply_stimulus(hdr(4'd1, 4'd0, 4'd6), 1'b0);
        for (int i = 0; i < 29; i++) apply_stimulus(64'h7700 + 64'(i), 1'b0);
        check_output("o_no_din_en", {63'h0, lookup_din_en}, 64'h0);
        check_output("o_no_act_en", {63'h0, action_en}, 64'h0);
        check_output("o_busy_drain", {63'h0, cfg_busy}, 64'h1);
        check_output("o_no_err_yet", {63'h0, cfg_err}, 64'h0);
        apply_stimulus(64'hDEAD, 1'b1);
        check_output("o_err_pulse", {63'h0, cfg_err}, 64'h1);
        check_output("o_busy_end", {63'h0, cfg_busy}, 64'h0);
        idle(3);
        check_output("o_cam_pulses", 64'(cam_cnt - cam_base), 64'h0);
        check_output("o_act_pulses", 64'(act_cnt - act_base), 64'h0);
        check_output("o_err_pulses", 64'(err_cnt - err_base), 64'h2);
        check_output("o_wr_cnt", {48'h0, cfg_wr_cnt}, 64'h3);

        $display("[TB] reset mid-mask, then WR_KEY");
        apply_stimulus(hdr(4'd2, 4'd0, 4'd2), 1'b0);
        for (int i = 0; i < 14; i++) apply_stimulus(64'hBEEF_0000 + 64'(i), 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(64'hCAFE_0000 + 64'(i), 1'b0);
        aresetn = 1'b0;
        #1;
        check_output("r_din_zero", {63'h0, lookup_din === '0}, 64'h1);
        check_output("r_mask_zero", {63'h0, lookup_din_mask === '0}, 64'h1);
        check_output("r_act_data", {39'h0, action_data_in}, 64'h0);
        check_output("r_act_addr", {60'h0, action_addr}, 64'h0);
        check_output("r_wr_cnt", {48'h0, cfg_wr_cnt}, 64'h0);
        check_output("r_busy", {63'h0, cfg_busy}, 64'h0);
        check_output("r_ready", {63'h0, cmd_ready}, 64'h0);
        idle(2);
        check_output("r_ready_held", {63'h0, cmd_ready}, 64'h0);
        aresetn = 1'b1;
        snap();
        exp_key  = '0;
        exp_mask = '0;
        apply_stimulus(hdr(4'd2, 4'd0, 4'hA), 1'b0);
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(64'h100 + 64'(i), 1'b0);
            exp_key = {exp_key[KL-65:0], 64'h100 + 64'(i)};
        end
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(64'hF0F0_0000_0000_0000 | 64'(i), i == 13);
            exp_mask = {exp_mask[KL-65:0], 64'hF0F0_0000_0000_0000 | 64'(i)};
        end
        check_output("w_din_en", {63'h0, lookup_din_en}, 64'h1);
        check_output("w_key_full", {63'h0, lookup_din === exp_key}, 64'h1);
        check_output("w_mask_full", {63'h0, lookup_din_mask === exp_mask}, 64'h1);
        check_output("w_mask_bot", lookup_din_mask[63:0], 64'hF0F0_0000_0000_000D);
        check_output("w_din_addr", {60'h0, lookup_din_addr}, 64'hA);
        check_output("w_ready_n1", {63'h0, cmd_ready}, 64'h0);
        check_output("w_wr_cnt", {48'h0, cfg_wr_cnt}, 64'h1);
        idle(1);
        check_output("w_ready_n2", {63'h0, cmd_ready}, 64'h1);
        idle(3);
        check_output("w_cam_pulses", 64'(cam_cnt - cam_base), 64'h1);
        check_output("w_act_pulses", 64'(act_cnt - act_base), 64'h0);
        check_output("w_err_pulses", 64'(err_cnt - err_base), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lookup_cfg_ctrl.md
Name: lookup_cfg_ctrl

Overview:
- Configuration sequencer for one lookup_engine stage.
- Accepts a 64-bit beat-serial control stream and assembles 896-bit key and mask words plus 25-bit action words.
- Issues single-cycle write strobes on the lookup_engine control channel (lookup_din*, action_*).
- Sits between the control-path deparser and each stage's lookup_engine; packets addressed to other stages are drained silently.

Parameters:
STAGE, 0, stage id this instance answers to (4-bit compare)
KEY_LEN, 896, CAM key width
MASK_LEN, 896, CAM mask width
ACTION_LEN, 25, action RAM word width
ADDR_W, 4, CAM/action RAM address width (16 entries)
C_DATA_W, 64, control beat width; KEY_LEN and MASK_LEN are multiples of it (14 beats each)

Ports:
axis_clk  in  1  clock
aresetn  in  1  async active-low reset
cmd_data  in  C_DATA_W  control beat
cmd_valid  in  1  beat valid
cmd_last  in  1  final beat of command
cmd_ready  out  1  beat accepted when valid&ready
lookup_din  out  KEY_LEN  CAM key write data
lookup_din_mask  out  MASK_LEN  CAM mask write data
lookup_din_addr  out  ADDR_W  CAM write address
lookup_din_en  out  1  CAM write strobe, one cycle
action_data_in  out  ACTION_LEN  action RAM write data
action_addr  out  ADDR_W  action RAM write address
action_en  out  1  action RAM write strobe, one cycle
cfg_busy  out  1  high whenever state != IDLE
cfg_err  out  1  one-cycle malformed-command pulse
cfg_wr_cnt  out  16  committed-command counter, wraps

Behaviour:
- Reset: async, aresetn low. All outputs 0, state IDLE, assembly registers cleared. A partial command in flight is discarded with no write; cmd_ready is 0 during reset.
- Header beat fields:
  - [63:60] opcode: 1 = WR_ENTRY (key+mask+action), 2 = WR_KEY (key+mask), 3 = WR_ACT (action only).
  - [59:56] stage id.
  - [ADDR_W-1:0] address.
  - All other bits ignored.
- Body beats:
  - Key: 14 beats, most-significant word first. The first key beat lands in [895:832]; assemble by left shift.
  - Mask: 14 beats, same ordering.
  - Action: 1 beat, bits [ACTION_LEN-1:0] used.
  - Expected totals: WR_ENTRY 30 beats, WR_KEY 29, WR_ACT 2.
- States: IDLE, KEY, MASK, ACT, COMMIT_CAM, COMMIT_ACT, DRAIN.
- Transitions:
  - IDLE, header accepted:
    - stage != STAGE -> DRAIN (or stay IDLE if cmd_last); no error.
    - Unknown opcode -> cfg_err, then DRAIN (or stay IDLE if cmd_last).
    - Opcode 1/2 -> KEY; opcode 3 -> ACT.
    - Header with cmd_last on a valid opcode -> cfg_err, back to IDLE.
  - KEY -> MASK after 14th key beat. MASK -> ACT (opcode 1) or COMMIT_CAM (opcode 2) after 14th mask beat.
  - ACT -> COMMIT_CAM (opcode 1) or COMMIT_ACT (opcode 3).
  - COMMIT_CAM -> COMMIT_ACT (opcode 1) or IDLE (opcode 2). COMMIT_ACT -> IDLE.
  - DRAIN -> IDLE on accepted cmd_last.
- Beat counter: 4-bit, cleared on entry to KEY/MASK.
- Handshake: cmd_ready = 1 in IDLE/KEY/MASK/ACT/DRAIN, 0 in COMMIT_*. No beat is accepted or lost while cmd_valid is low; bubbles are allowed anywhere.
- Length errors:
  - Early cmd_last (before the final expected beat): cfg_err pulse the next cycle, -> IDLE, no write issued.
  - Missing cmd_last on the final expected beat: -> DRAIN, no write, cfg_err pulse when the last beat is accepted.
- Latency (final beat accepted in cycle N):
  - WR_ENTRY: lookup_din_en in N+1, action_en in N+2.
  - WR_KEY: lookup_din_en in N+1.
  - WR_ACT: action_en in N+1.
  - Next header accepted at the earliest in N+2 (WR_KEY/WR_ACT) or N+3 (WR_ENTRY).
- Data/address hold: lookup_din, lookup_din_mask, lookup_din_addr, action_data_in and action_addr are registered and hold their values after the strobe until the next commit.
- cfg_wr_cnt: +1 on the final strobe of each successful command; wraps 0xFFFF -> 0. Errors and drained commands do not count.

Decomposition:
- Package lookup_cfg_pkg holds:
  - opcode constants OP_WR_ENTRY/OP_WR_KEY/OP_WR_ACT;
  - header field bit positions;
  - state enum;
  - KEY_BEATS = KEY_LEN/C_DATA_W.
- One natural sub-module: cfg_wide_shreg, a parameterised C_DATA_W-in, N-word left-shift assembler. It is instantiated twice (key and mask).

Test Plan:
- WR_ENTRY, stage 0, addr 5, key beats 0x0..0xD, mask all 0xFFFF_FFFF_FFFF_FFFF, action 0x1ABCDEF -> lookup_din[895:832]=0, [63:0]=0xD, lookup_din_addr=5, lookup_din_en one cycle at N+1; action_en at N+2 with action_data_in=0x1ABCDEF, action_addr=5; cfg_wr_cnt=1.
- WR_ACT addr 3, action 0x0FF, cmd_valid toggled every other cycle -> single action_en with action_addr=3, no lookup_din_en; cfg_wr_cnt increments.
- Header with stage=1 on a STAGE=0 instance, 30-beat body -> all beats accepted, no strobes, no cfg_err, cfg_busy low after last.
- WR_ENTRY with cmd_last on the 10th key beat -> cfg_err pulse, no strobes, next WR_ACT executes normally.
- Unknown opcode 0x7 with a 3-beat body -> cfg_err, drain, no strobes; then a 31-beat WR_ENTRY without last on beat 30 -> no write, cfg_err on the last beat.
- aresetn low mid-mask -> all outputs 0 immediately; after release a fresh WR_KEY commits with only the new key/mask.
